// File: rtl/pipeline_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds FSM state and grant encodings plus the round-robin pick helper.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    // On a tie the port that was not granted last time wins.
    function automatic gnt_t rr_pick(input logic i_pend, input logic d_pend, input gnt_t last);
        if (i_pend && d_pend) begin
            return (last == GNT_I) ? GNT_D : GNT_I;
        end else if (d_pend) begin
            return GNT_D;
        end else begin
            return GNT_I;
        end
    endfunction

endpackage

// File: rtl/arb_timer.sv
// Backend wait counter: cleared on grant, counts busy cycles without acknowledge.
// expired flags the cycle that is the TIMEOUT-th consecutive cycle without acknowledge.
module arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    assign expired = en && (r_count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one backend memory port,
// with round-robin tie-break and a sticky timeout error.
//
// state | meaning
// IDLE  | no access outstanding; grant a pending request
// IBUSY | fetch access on the backend, waiting for MemAck
// DBUSY | data access on the backend, waiting for MemAck
module mem_arbiter
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IReq,
    input  logic [XLEN-1:0] IAddr,
    output logic [XLEN-1:0] IRdata,
    output logic            IValid,
    input  logic            DReq,
    input  logic            DWe,
    input  logic [XLEN-1:0] DAddr,
    input  logic [XLEN-1:0] DWdata,
    output logic [XLEN-1:0] DRdata,
    output logic            DValid,
    output logic            MemReq,
    output logic            MemWe,
    output logic [XLEN-1:0] MemAddr,
    output logic [XLEN-1:0] MemWdata,
    input  logic [XLEN-1:0] MemRdata,
    input  logic            MemAck,
    output logic            StallF,
    output logic            StallM,
    output logic            Err
);

    arb_state_t      r_state;
    gnt_t            r_last_gnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [XLEN-1:0] r_irdata;
    logic [XLEN-1:0] r_drdata;
    logic            r_ivalid;
    logic            r_dvalid;
    logic            r_err;

    logic            w_i_pend;
    logic            w_d_pend;
    logic            w_grant;
    gnt_t            w_pick;
    logic            w_busy;
    logic            w_tmr_en;
    logic            w_expired;

    // A request completing this cycle is not pending, so it cannot be regranted.
    assign w_i_pend = IReq && !r_ivalid;
    assign w_d_pend = DReq && !r_dvalid;
    assign w_grant  = (r_state == IDLE) && (w_i_pend || w_d_pend);
    assign w_pick   = rr_pick(w_i_pend, w_d_pend, r_last_gnt);
    assign w_busy   = (r_state == IBUSY) || (r_state == DBUSY);
    assign w_tmr_en = w_busy && !MemAck;

    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_grant),
        .en      (w_tmr_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last_gnt  <= GNT_I;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_irdata    <= '0;
            r_drdata    <= '0;
            r_ivalid    <= 1'b0;
            r_dvalid    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ivalid <= 1'b0;
            r_dvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_last_gnt <= w_pick;
                        r_mem_req  <= 1'b1;
                        if (w_pick == GNT_D) begin
                            r_state     <= DBUSY;
                            r_mem_we    <= DWe;
                            r_mem_addr  <= DAddr;
                            r_mem_wdata <= DWdata;
                        end else begin
                            r_state     <= IBUSY;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= IAddr;
                            r_mem_wdata <= '0;
                        end
                    end
                end
                IBUSY: begin
                    if (MemAck) begin
                        r_irdata  <= MemRdata;
                        r_ivalid  <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_expired) begin
                        r_irdata  <= '0;
                        r_ivalid  <= 1'b1;
                        r_err     <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                DBUSY: begin
                    if (MemAck) begin
                        // Stores complete without disturbing the last load value.
                        if (!r_mem_we) begin
                            r_drdata <= MemRdata;
                        end
                        r_dvalid  <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_expired) begin
                        r_drdata  <= '0;
                        r_dvalid  <= 1'b1;
                        r_err     <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign IRdata   = r_irdata;
    assign IValid   = r_ivalid;
    assign DRdata   = r_drdata;
    assign DValid   = r_dvalid;
    assign MemReq   = r_mem_req;
    assign MemWe    = r_mem_we;
    assign MemAddr  = r_mem_addr;
    assign MemWdata = r_mem_wdata;
    assign Err      = r_err;
    assign StallF   = IReq && !r_ivalid;
    assign StallM   = DReq && !r_dvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random request rounds, checked
// against a transaction-level model (grant order, backend memory, sticky error).
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        IReq, DReq, DWe, MemAck;
    logic [31:0] IAddr, DAddr, DWdata, MemRdata;
    logic [31:0] IRdata, DRdata, MemAddr, MemWdata;
    logic        IValid, DValid, MemReq, MemWe, StallF, StallM, Err;

    int n_tests = 0;
    int n_fail  = 0;

    // transaction-level model
    bit          m_last_d;
    bit          m_err;
    logic [31:0] m_irdata, m_drdata;
    bit          i_act, d_act;
    logic [31:0] mem [bit [31:0]];

    mem_arbiter #(.TIMEOUT(TO), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IValid(IValid),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
        .DRdata(DRdata), .DValid(DValid),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemRdata(MemRdata), .MemAck(MemAck),
        .StallF(StallF), .StallM(StallM), .Err(Err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic model_reset();
        m_last_d = 1'b0;
        m_err    = 1'b0;
        m_irdata = '0;
        m_drdata = '0;
        i_act    = 1'b0;
        d_act    = 1'b0;
    endtask

    task automatic reset_dut();
        reset  = 1'b1;
        IReq   = 1'b0;
        DReq   = 1'b0;
        MemAck = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Drive the backend for the access of one port and check its completion.
    task automatic serve(input bit port_d, input int dly, input int req_lat);
        int          n;
        bit          timed;
        logic [31:0] val;
        logic [31:0] a;
        n = 0;
        timed = 1'b0;
        while (MemReq !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
        check("mreq_latency", n, req_lat);
        a = port_d ? DAddr : IAddr;
        check("mem_addr", MemAddr, a);
        check("mem_we", MemWe, port_d ? DWe : 1'b0);
        if (port_d) check("mem_wdata", MemWdata, DWdata);
        for (int k = 0; k < TO + 2; k++) begin
            if (k == dly) begin
                val = (port_d && DWe) ? $urandom : mem_rd(a);
                MemAck   = 1'b1;
                MemRdata = val;
                tick();
                MemAck   = 1'b0;
                MemRdata = $urandom;
                if (port_d) begin
                    if (DWe) mem[a] = DWdata;
                    else m_drdata = val;
                end else begin
                    m_irdata = val;
                end
                break;
            end
            MemRdata = $urandom;
            tick();
            if (k + 1 == TO) begin
                timed = 1'b1;
                break;
            end
            check("busy_mreq", MemReq, 1'b1);
            check("busy_ivalid", IValid, 1'b0);
            check("busy_dvalid", DValid, 1'b0);
            check("busy_stallf", StallF, i_act);
            check("busy_stallm", StallM, d_act);
        end
        if (timed) begin
            if (port_d) m_drdata = '0;
            else m_irdata = '0;
            m_err = 1'b1;
        end
        check("done_ivalid", IValid, !port_d);
        check("done_dvalid", DValid, port_d);
        check("done_mreq", MemReq, 1'b0);
        check("done_irdata", IRdata, m_irdata);
        check("done_drdata", DRdata, m_drdata);
        check("done_err", Err, m_err);
        check("done_stallf", StallF, i_act && port_d);
        check("done_stallm", StallM, d_act && !port_d);
        m_last_d = port_d;
        // requester keeps Req high through its Valid cycle
        tick();
        if (port_d) begin
            DReq = 1'b0;
            d_act = 1'b0;
        end else begin
            IReq = 1'b0;
            i_act = 1'b0;
        end
    endtask

    task automatic round(input bit do_i, input bit do_d, input logic [31:0] ia,
                         input bit dwe, input logic [31:0] da, input logic [31:0] dwd,
                         input int dly_i, input int dly_d);
        bit first_d;
        IReq = do_i; IAddr = ia;
        DReq = do_d; DWe = dwe; DAddr = da; DWdata = dwd;
        i_act = do_i; d_act = do_d;
        #1;
        check("req_stallf", StallF, do_i);
        check("req_stallm", StallM, do_d);
        first_d = do_d && (!do_i || !m_last_d);
        if (first_d) begin
            serve(1'b1, dly_d, 1);
            if (do_i) serve(1'b0, dly_i, 0);
        end else begin
            serve(1'b0, dly_i, 1);
            if (do_d) serve(1'b1, dly_d, 0);
        end
        check("round_idle_mreq", MemReq, 1'b0);
        check("round_idle_ivalid", IValid, 1'b0);
        check("round_idle_dvalid", DValid, 1'b0);
    endtask

    initial begin
        IAddr = '0; DAddr = '0; DWdata = '0; DWe = 1'b0; MemRdata = '0;
        reset_dut();

        check("rst_mreq", MemReq, 1'b0);
        check("rst_ivalid", IValid, 1'b0);
        check("rst_dvalid", DValid, 1'b0);
        check("rst_err", Err, 1'b0);
        check("rst_irdata", IRdata, 32'h0);
        check("rst_drdata", DRdata, 32'h0);
        check("rst_maddr", MemAddr, 32'h0);
        check("rst_mwdata", MemWdata, 32'h0);
        check("rst_stallf", StallF, 1'b0);
        check("rst_stallm", StallM, 1'b0);

        // acknowledge while idle is ignored
        MemAck = 1'b1; MemRdata = 32'hFFFF_FFFF;
        tick();
        MemAck = 1'b0;
        check("idle_ack_ivalid", IValid, 1'b0);
        check("idle_ack_dvalid", DValid, 1'b0);
        check("idle_ack_irdata", IRdata, 32'h0);
        check("idle_ack_mreq", MemReq, 1'b0);

        // fetch with immediate acknowledge
        mem[32'h4] = 32'h0050_0113;
        round(1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0, 0, 0);
        check("fetch_irdata", IRdata, 32'h0050_0113);

        // simultaneous requests after reset: data store first, then fetch
        reset_dut();
        round(1'b1, 1'b1, 32'h8, 1'b1, 32'h100, 32'hDEAD_BEEF, 0, 1);
        check("store_mem", mem_rd(32'h100), 32'hDEAD_BEEF);

        // load that never gets acknowledged
        round(1'b0, 1'b1, 32'h0, 1'b0, 32'h100, 32'h0, 0, TO + 3);
        check("timeout_drdata", DRdata, 32'h0);
        check("timeout_err", Err, 1'b1);
        round(1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0, 1, 0);
        check("err_sticky", Err, 1'b1);

        // reset in the second DBUSY cycle
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h20; DWdata = 32'h0;
        tick();
        check("rst_busy_mreq1", MemReq, 1'b1);
        tick();
        reset = 1'b1;
        DReq  = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        check("rst_busy_mreq", MemReq, 1'b0);
        check("rst_busy_dvalid", DValid, 1'b0);
        check("rst_busy_err", Err, 1'b0);
        tick();
        check("rst_busy_dvalid2", DValid, 1'b0);
        check("rst_busy_mreq2", MemReq, 1'b0);

        // random rounds
        for (int r = 0; r < 60; r++) begin
            bit do_i, do_d;
            int sel, di, dd;
            sel  = $urandom_range(1, 3);
            do_i = sel[0];
            do_d = sel[1];
            di = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
            dd = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
            round(do_i, do_d, 32'($urandom_range(0, 7)) << 2, 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 7)) << 2, $urandom, di, dd);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
